// File: rtl/crg_pkg.sv
// Shared clock-and-reset-generator types and defaults.
package crg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } clk_div_state_e;

    localparam int CLK_DIV_WIDTH = 8;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with glitch-free start/stop and
// period-boundary application of new divide ratios.
module clk_div_prog
    import crg_pkg::*;
#(
    parameter int                   DIV_WIDTH = CLK_DIV_WIDTH,
    parameter logic [DIV_WIDTH-1:0] RESET_DIV = '0
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    input  logic                 clk_en_i,
    output logic                 clk_o,
    output logic                 tick_o,
    output logic                 active_o,
    output logic [DIV_WIDTH-1:0] cur_div_o,
    output clk_div_state_e       state_o
);

    clk_div_state_e       state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] pend_div_q;
    logic                 pending_q;
    logic                 clk_q, tick_q, active_q;
    logic                 tick_d;
    logic                 at_limit;
    logic                 xfer;
    logic                 apply;

    // Handshake: a transfer happens on a cycle where div_valid_i and
    // div_ready_o are both high; the producer holds div_i stable until then.
    // A single holding slot means ready is simply "nothing pending".
    assign at_limit = (cnt_q == div_q);
    assign xfer     = div_valid_i && !pending_q;
    assign apply    = pending_q && ((state_q == IDLE) || (state_q == LOW && at_limit));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (clk_en_i) begin
                    state_d = HIGH;
                    tick_d  = 1'b1;
                end
            end
            HIGH: begin
                // High phase always completes; enable is only honoured at the low boundary.
                if (at_limit) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            LOW: begin
                if (at_limit) begin
                    cnt_d = '0;
                    if (clk_en_i) begin
                        state_d = HIGH;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are dedicated flops fed from the next-state decode so clk_o never glitches.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= RESET_DIV;
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_q    <= (state_d == HIGH);
            tick_q   <= tick_d;
            active_q <= (state_d != IDLE);
            if (xfer) begin
                pend_div_q <= div_i;
                pending_q  <= 1'b1;
            end else if (apply) begin
                div_q     <= pend_div_q;
                pending_q <= 1'b0;
            end
        end
    end

    assign div_ready_o = !pending_q;
    assign clk_o       = clk_q;
    assign tick_o      = tick_q;
    assign active_o    = active_q;
    assign cur_div_o   = div_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: scoreboard of expected {active, clk, tick} per cycle.
module tb_clk_div_prog;
    import crg_pkg::*;

    localparam int W = 8;

    logic           clk_i = 1'b0;
    logic           arst_i;
    logic [W-1:0]   div_i;
    logic           div_valid_i;
    logic           div_ready_o;
    logic           clk_en_i;
    logic           clk_o;
    logic           tick_o;
    logic           active_o;
    logic [W-1:0]   cur_div_o;
    clk_div_state_e state_o;

    logic [2:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    clk_div_prog #(.DIV_WIDTH(W), .RESET_DIV('0)) dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .div_i      (div_i),
        .div_valid_i(div_valid_i),
        .div_ready_o(div_ready_o),
        .clk_en_i   (clk_en_i),
        .clk_o      (clk_o),
        .tick_o     (tick_o),
        .active_o   (active_o),
        .cur_div_o  (cur_div_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected {active, clk, tick} for one full period of divide field d.
    task automatic push_period(input int d);
        exp_q.push_back(3'b111);
        for (int i = 0; i < d; i++) exp_q.push_back(3'b110);
        for (int i = 0; i <= d; i++) exp_q.push_back(3'b100);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
    endtask

    task automatic run_check(input int n);
        logic [2:0] exp;
        logic [2:0] got;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            got = {active_o, clk_o, tick_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wave: scoreboard empty, got %b at %0t", got, $time);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL wave: {active,clk,tick} got %b expected %b at %0t", got, exp, $time);
                end
            end
        end
    endtask

    task automatic do_reset();
        arst_i      = 1'b1;
        clk_en_i    = 1'b0;
        div_valid_i = 1'b0;
        div_i       = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
    endtask

    // Transfer d while IDLE and let it apply on the following cycle.
    task automatic load_idle(input logic [W-1:0] d);
        checks++;
        if (div_ready_o !== 1'b1) begin
            errors++; $display("FAIL load_ready_pre: got %b expected 1", div_ready_o);
        end
        div_i = d; div_valid_i = 1'b1;
        @(negedge clk_i);
        div_valid_i = 1'b0;
        checks++;
        if (div_ready_o !== 1'b0) begin
            errors++; $display("FAIL load_ready_fall: got %b expected 0", div_ready_o);
        end
        @(negedge clk_i);
        checks++;
        if (cur_div_o !== d || div_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL load_apply: cur_div %0d ready %b expected %0d 1", cur_div_o, div_ready_o, d);
        end
    endtask

    task automatic test_reset();
        arst_i = 1'b1; clk_en_i = 1'b1; div_valid_i = 1'b0; div_i = '0;
        @(negedge clk_i);
        checks++;
        if ({clk_o, tick_o, active_o, div_ready_o} !== 4'b0001 || cur_div_o !== '0 || state_o !== IDLE) begin
            errors++;
            $display("FAIL reset_values: clk %b tick %b active %b ready %b cur_div %0d state %0d",
                     clk_o, tick_o, active_o, div_ready_o, cur_div_o, state_o);
        end
        arst_i = 1'b0;
        #1;
        checks++;
        if (clk_o !== 1'b0) begin
            errors++; $display("FAIL cycle0_clk: got %b expected 0", clk_o);
        end
        for (int i = 0; i < 3; i++) push_period(0);
        run_check(6);
        clk_en_i = 1'b0;
        push_idle(2);
        run_check(2);
    endtask

    task automatic test_div_idle();
        do_reset();
        load_idle(8'd2);
        clk_en_i = 1'b1;
        push_period(2);
        push_period(2);
        run_check(12);
        clk_en_i = 1'b0;
        push_idle(1);
        run_check(1);
    endtask

    task automatic test_change_mid_high();
        clk_en_i = 1'b1;
        push_period(2);
        for (int i = 0; i < 3; i++) push_period(0);
        push_idle(1);
        run_check(2);
        div_i = 8'd0; div_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_check(1);
            div_valid_i = 1'b0;
            checks++;
            if (div_ready_o !== 1'b0) begin
                errors++; $display("FAIL mid_ready_low: cycle %0d got %b expected 0", i, div_ready_o);
            end
        end
        run_check(1);
        checks++;
        if (div_ready_o !== 1'b1 || cur_div_o !== 8'd0) begin
            errors++;
            $display("FAIL mid_apply: ready %b cur_div %0d expected 1 0", div_ready_o, cur_div_o);
        end
        run_check(5);
        clk_en_i = 1'b0;
        run_check(1);
    endtask

    task automatic test_stop();
        do_reset();
        load_idle(8'd3);
        clk_en_i = 1'b1;
        push_period(3);
        push_idle(3);
        run_check(1);
        clk_en_i = 1'b0;
        run_check(10);
    endtask

    task automatic test_back_to_back();
        logic acc;
        do_reset();
        load_idle(8'd1);
        clk_en_i = 1'b1;
        push_period(1);
        push_period(2);
        push_period(5);
        run_check(1);
        div_i = 8'd2; div_valid_i = 1'b1;
        acc = div_ready_o;
        for (int i = 1; i < 22; i++) begin
            run_check(1);
            if (acc) begin
                if (div_i == 8'd2) div_i = 8'd5;
                else div_valid_i = 1'b0;
            end
            acc = div_valid_i && div_ready_o;
            if (i == 3) begin
                checks++;
                if (div_ready_o !== 1'b0 || cur_div_o !== 8'd1) begin
                    errors++;
                    $display("FAIL b2b_hold: ready %b cur_div %0d expected 0 1", div_ready_o, cur_div_o);
                end
            end
            if (i == 4) begin
                checks++;
                if (cur_div_o !== 8'd2) begin
                    errors++; $display("FAIL b2b_first: cur_div %0d expected 2", cur_div_o);
                end
            end
            if (i == 10) begin
                checks++;
                if (cur_div_o !== 8'd5) begin
                    errors++; $display("FAIL b2b_second: cur_div %0d expected 5", cur_div_o);
                end
            end
        end
        clk_en_i = 1'b0;
        push_idle(1);
        run_check(1);
        checks++;
        if (div_valid_i !== 1'b0 || div_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: valid %b ready %b expected 0 1", div_valid_i, div_ready_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_idle(8'd7);
        clk_en_i = 1'b1;
        exp_q.push_back(3'b111);
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b110);
        run_check(3);
        arst_i = 1'b1;
        #1;
        checks++;
        if ({clk_o, tick_o, active_o, div_ready_o} !== 4'b0001 || cur_div_o !== '0) begin
            errors++;
            $display("FAIL async_reset: clk %b tick %b active %b ready %b cur_div %0d",
                     clk_o, tick_o, active_o, div_ready_o, cur_div_o);
        end
        @(negedge clk_i);
        arst_i = 1'b0;
        push_period(0);
        push_period(0);
        run_check(4);
        clk_en_i = 1'b0;
        push_idle(1);
        run_check(1);
    endtask

    initial begin
        test_reset();
        test_div_idle();
        test_change_mid_high();
        test_stop();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover: %0d expected entries unconsumed", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
